// File: rtl/dac_out_pkg.sv
// Shared types and defaults for the DAC output pacing stage.
// Holds the controller state encoding and the FIFO pointer sizing helper.
package dac_out_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RUN,
        DRAIN
    } state_t;

    localparam int DAC_DW         = 16;
    localparam int DAC_DIV_W      = 16;
    localparam int DAC_FIFO_DEPTH = 4;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous sample FIFO with registered occupancy count and a
// first-word-fall-through head, so the controller can latch it on a tick.
module dac_sample_fifo
    import dac_out_pkg::*;
#(
    parameter int DW    = DAC_DW,
    parameter int DEPTH = DAC_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dac_out_ctrl.sv
// DAC output pacing controller: releases one buffered sample every Div+1
// clocks and owns the tristate control of the output buffer bank.
module dac_out_ctrl
    import dac_out_pkg::*;
#(
    parameter int DW         = DAC_DW,
    parameter int DIV_W      = DAC_DIV_W,
    parameter int FIFO_DEPTH = DAC_FIFO_DEPTH,
    parameter int SETTLE_CYC = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             En,
    input  logic [DIV_W-1:0] Div,
    input  logic [DW-1:0]    S_Data,
    input  logic             S_Valid,
    output logic             S_Ready,
    output logic [DW-1:0]    Dout,
    output logic             Con_T,
    output logic             Dac_Wr,
    output logic             Underflow,
    output logic             Busy
);

    localparam int SW = $clog2(SETTLE_CYC + 1);

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [SW-1:0]    settle_cnt;
    logic [DW-1:0]    head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ticking;
    logic             tick;
    logic             pop;

    assign S_Ready = !fifo_full && !RST;
    assign Con_T   = (state == IDLE);
    assign Busy    = (state != IDLE);
    assign ticking = (state == RUN) || (state == DRAIN);
    assign tick    = ticking && (cnt == div_q);
    assign pop     = tick && !fifo_empty;

    dac_sample_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (S_Valid && S_Ready),
        .push_data (S_Data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (En) state_nxt = SETTLE;
            SETTLE: begin
                if (!En)                                state_nxt = IDLE;
                else if (settle_cnt == SW'(SETTLE_CYC - 1)) state_nxt = RUN;
            end
            RUN:    if (!En) state_nxt = DRAIN;
            // An empty FIFO at a drain tick means the channel has run dry.
            DRAIN: begin
                if (En)                      state_nxt = RUN;
                else if (tick && fifo_empty) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            div_q      <= '0;
            settle_cnt <= '0;
            Dout       <= '0;
            Dac_Wr     <= 1'b0;
            Underflow  <= 1'b0;
        end else begin
            state      <= state_nxt;
            Dac_Wr     <= pop;
            settle_cnt <= (state == SETTLE) ? settle_cnt + SW'(1) : '0;

            if (pop)                                    Dout <= head;
            else if (state == DRAIN && state_nxt == IDLE) Dout <= '0;

            if (state == IDLE && state_nxt == SETTLE)      Underflow <= 1'b0;
            else if (state == RUN && tick && fifo_empty)  Underflow <= 1'b1;

            // Div is only picked up at a period boundary, never mid-period.
            if ((state == SETTLE && state_nxt == RUN) || tick) begin
                cnt   <= '0;
                div_q <= Div;
            end else if (ticking) begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dac_out_ctrl.sv
// Directed-plus-random bench for dac_out_ctrl; expected strobe timing comes
// from the sample-period arithmetic and expected data from a sample queue.
module tb_dac_out_ctrl;

    localparam int SETTLE = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        En = 1'b0;
    logic [15:0] Div = '0;
    logic [15:0] S_Data = '0;
    logic        S_Valid = 1'b0;
    logic        S_Ready;
    logic [15:0] Dout;
    logic        Con_T;
    logic        Dac_Wr;
    logic        Underflow;
    logic        Busy;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] model[$];
    logic [15:0] last = '0;

    dac_out_ctrl #(
        .DW         (16),
        .DIV_W      (16),
        .FIFO_DEPTH (4),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .En        (En),
        .Div       (Div),
        .S_Data    (S_Data),
        .S_Valid   (S_Valid),
        .S_Ready   (S_Ready),
        .Dout      (Dout),
        .Con_T     (Con_T),
        .Dac_Wr    (Dac_Wr),
        .Underflow (Underflow),
        .Busy      (Busy)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_outputs(input string tag, input bit wr, input bit uf, input bit idle);
        if (wr) last = (model.size() > 0) ? model.pop_front() : 16'hDEAD;
        if (idle) last = '0;
        check({tag, " wr"},   32'(Dac_Wr),    32'(wr));
        check({tag, " dout"}, 32'(Dout),      32'(last));
        check({tag, " uf"},   32'(Underflow), 32'(uf));
        check({tag, " cont"}, 32'(Con_T),     32'(idle));
        check({tag, " busy"}, 32'(Busy),      32'(!idle));
    endtask

    task automatic push(input logic [15:0] d);
        check("push rdy", 32'(S_Ready), 32'd1);
        S_Valid = 1'b1;
        S_Data  = d;
        model.push_back(d);
        step();
        S_Valid = 1'b0;
    endtask

    task automatic do_reset();
        En = 1'b0;
        S_Valid = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        step();
        model.delete();
        last = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (Busy !== 1'b0 && n < 64) begin
            step();
            n++;
        end
        check({tag, " idle_to"}, 32'(n < 64), 32'd1);
    endtask

    initial begin
        int p, first, tend, d;
        bit wr, acc;
        logic [15:0] base, x, expv;

        // Reset values while RST is asserted
        #1;
        check("rst cont", 32'(Con_T), 32'd1);
        check("rst dout", 32'(Dout), 32'd0);
        check("rst wr", 32'(Dac_Wr), 32'd0);
        check("rst uf", 32'(Underflow), 32'd0);
        check("rst busy", 32'(Busy), 32'd0);
        check("rst rdy", 32'(S_Ready), 32'd0);
        step();
        step();
        RST = 1'b0;
        #1;
        check("rel rdy", 32'(S_Ready), 32'd1);

        // Paced output: Div=3, three prefilled samples
        Div = 16'd3;
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        En = 1'b1;
        step();
        check_outputs("paced e", 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            wr = (k >= 6) && ((k - 6) % 4 == 0) && ((k - 6) / 4 < 3);
            check_outputs("paced", wr, k >= 18, 0);
        end
        En = 1'b0;
        wait_idle("paced");
        check_outputs("paced idle", 0, 1, 1);
        En = 1'b1;
        step();
        check_outputs("rearm", 0, 0, 0);
        En = 1'b0;
        step();
        check_outputs("settle abort", 0, 0, 1);

        // Underflow with random divider and one sample
        do_reset();
        d = $urandom_range(0, 4);
        Div = 16'(d);
        push(16'($urandom));
        En = 1'b1;
        step();
        check_outputs("uf e", 0, 0, 0);
        p = d + 1;
        first = SETTLE + p;
        for (int k = 1; k <= first + 2 * p; k++) begin
            step();
            check_outputs("uf", k == first, k >= first + p, 0);
        end
        En = 1'b0;
        wait_idle("uf");
        check_outputs("uf idle", 0, 1, 1);
        En = 1'b1;
        step();
        check_outputs("uf rearm", 0, 0, 0);
        En = 1'b0;
        step();

        // Full throughput at Div=0 with a continuous incrementing source
        do_reset();
        Div = '0;
        base = 16'($urandom);
        S_Data = base;
        S_Valid = 1'b1;
        En = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            acc = S_Ready;
            step();
            if (acc) begin
                model.push_back(S_Data);
                S_Data = S_Data + 16'd1;
            end
            if (k >= 1) begin
                check_outputs("thru", k >= 3, 0, 0);
                if (k >= 3) begin
                    expv = base + 16'(k - 3);
                    check("thru inc", 32'(Dout), 32'(expv));
                end
            end
        end
        S_Valid = 1'b0;

        // Drain: En dropped after the first strobe
        do_reset();
        Div = 16'd2;
        for (int i = 0; i < 4; i++) push(16'($urandom));
        En = 1'b1;
        step();
        check_outputs("drain e", 0, 0, 0);
        p = 3;
        first = SETTLE + p;
        tend = first + 4 * p;
        for (int k = 1; k <= tend + 5; k++) begin
            step();
            wr = (k >= first) && ((k - first) % p == 0) && (k < tend);
            check_outputs("drain", wr, 0, k >= tend);
            if (k == first) En = 1'b0;
        end

        // Backpressure on a full FIFO and a mid-period divider change
        do_reset();
        Div = 16'd5;
        for (int i = 0; i < 4; i++) push(16'($urandom));
        x = 16'($urandom);
        S_Data = x;
        S_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp full rdy", 32'(S_Ready), 32'd0);
            step();
        end
        En = 1'b1;
        step();
        for (int k = 1; k <= 24; k++) begin
            acc = S_Valid && S_Ready;
            step();
            if (acc) begin
                model.push_back(x);
                S_Valid = 1'b0;
            end
            wr = (k == 8) || (k == 14) || (k == 16) || (k == 18) || (k == 20);
            check_outputs("bp", wr, k >= 22, 0);
            if (k <= 8) check("bp rdy", 32'(S_Ready), 32'(k == 8));
            if (k == 10) Div = 16'd1;
        end
        check("bp none lost", 32'(model.size()), 32'd0);

        // Asynchronous reset mid-RUN discards queued samples
        do_reset();
        d = $urandom_range(1, 3);
        Div = 16'(d);
        for (int i = 0; i < 4; i++) push(16'($urandom));
        En = 1'b1;
        step();
        p = d + 1;
        first = SETTLE + p;
        for (int k = 1; k <= first + 1; k++) begin
            step();
            check_outputs("mid", k == first, 0, 0);
        end
        RST = 1'b1;
        #1;
        check("arst cont", 32'(Con_T), 32'd1);
        check("arst dout", 32'(Dout), 32'd0);
        check("arst busy", 32'(Busy), 32'd0);
        check("arst wr", 32'(Dac_Wr), 32'd0);
        check("arst rdy", 32'(S_Ready), 32'd0);
        En = 1'b0;
        step();
        RST = 1'b0;
        #1;
        check("arst rel rdy", 32'(S_Ready), 32'd1);
        model.delete();
        last = '0;
        Div = '0;
        En = 1'b1;
        step();
        for (int k = 1; k <= 4; k++) begin
            step();
            check_outputs("discard", 0, k >= 3, 0);
        end
        En = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
